// File: rtl/funct_generator_pkg.sv
// Shared types and constants for the function-generator controller.
// The FSM state and mode enums live here so the top and any bench agree on encodings.
package funct_generator_pkg;

  localparam int unsigned NUM_WAVES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_SWEEP = 1'b1
  } mode_e;

  // Round-robin successor of a waveform index, wrapping at the last waveform.
  function automatic logic [1:0] next_wave(input logic [1:0] wave);
    if (wave == 2'(NUM_WAVES - 1)) begin
      return 2'd0;
    end
    return wave + 2'd1;
  endfunction

endpackage

// File: rtl/funct_generator_ctrl.sv
// Controller that streams multiplexer samples into a FIFO, in fixed or sweep mode.
// Define FGEN_STALL_CNT_EN to add the saturating HOLD-cycle counter output stall_cnt_o.
module funct_generator_ctrl
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   mode_i,
  input  logic [1:0]             wave_sel_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  input  logic                   fifo_full_i,
  output logic [1:0]             sel_o,
  output logic                   enh_o,
  output logic                   fifo_wr_o,
  output logic                   busy_o
`ifdef FGEN_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt_o
`endif
);

  localparam logic [DWELL_WIDTH-1:0] DwellOne = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic [1:0]               sel_q, sel_d;
  logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0]   count_q, count_d;
  logic                     wr;
  logic                     accept_start;

  assign accept_start = (state_q == ST_IDLE) && start_i && !stop_i;
  assign wr           = (state_q == ST_RUN) && !fifo_full_i;

  assign fifo_wr_o = wr;
  assign enh_o     = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign busy_o    = (state_q != ST_IDLE);
  assign sel_o     = sel_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_start) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(mode_i);
          sel_d   = wave_sel_i;
          // A zero dwell would never complete, so it is stored as one.
          dwell_d = (dwell_i == '0) ? DwellOne : dwell_i;
          count_d = '0;
        end
      end

      ST_RUN: begin
        if (wr) begin
          if (count_q == dwell_q - DwellOne) begin
            count_d = '0;
            if (mode_q == MODE_SWEEP) begin
              sel_d = next_wave(sel_q);
            end
          end else begin
            count_d = count_q + DwellOne;
          end
        end
        if (stop_i) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (fifo_full_i) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (!fifo_full_i) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FIXED;
      sel_q   <= 2'd0;
      dwell_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      count_q <= count_d;
    end
  end

`ifdef FGEN_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of HOLD cycles, restarted by each accepted start.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept_start) begin
      stall_cnt_d = '0;
    end else if ((state_q == ST_HOLD) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/funct_generator_ctrl.md
FUNCT_GENERATOR_CTRL -- requirements
Module: funct_generator_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning sample width of the downstream multiplexer datapath.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16, meaning width of the per-waveform dwell count.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  single-cycle request to begin generation.
REQ-007 stop_i  input  1  single-cycle request to end generation.
REQ-008 mode_i  input  1  0 = fixed waveform, 1 = round-robin sweep of all four waveforms.
REQ-009 wave_sel_i  input  2  waveform in fixed mode; first waveform in sweep mode.
REQ-010 dwell_i  input  DWELL_WIDTH  number of samples written per waveform before advancing.
REQ-011 fifo_full_i  input  1  downstream FIFO full flag.
REQ-012 sel_o  output  2  multiplexer select.
REQ-013 enh_o  output  1  multiplexer enable.
REQ-014 fifo_wr_o  output  1  FIFO write strobe; one sample is written per asserted cycle.
REQ-015 busy_o  output  1  high when not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and HOLD, with the state type defined in the shared package.
REQ-017 In IDLE, start_i=1 and stop_i=0 SHALL latch mode_i, wave_sel_i and dwell_i, and SHALL enter RUN on the next edge.
REQ-018 The latched configuration SHALL remain fixed until the next IDLE; input changes while busy_o=1 SHALL be ignored.
REQ-019 A latched dwell of 0 SHALL be treated as 1.
REQ-020 In RUN with fifo_full_i=0, fifo_wr_o SHALL be 1; fifo_wr_o is a combinational function of state and fifo_full_i.
REQ-021 In RUN with fifo_full_i=1, fifo_wr_o SHALL be 0 in the same cycle, and the FSM SHALL enter HOLD.
REQ-022 In HOLD, fifo_wr_o SHALL be 0, enh_o SHALL stay 1 and sel_o SHALL stay unchanged.
REQ-023 HOLD SHALL return to RUN on the edge after fifo_full_i=0.
REQ-024 The dwell counter SHALL increment only on cycles with fifo_wr_o=1.
REQ-025 When a write occurs with count = dwell-1, the counter SHALL clear to 0.
REQ-026 On that same dwell-completing write in sweep mode, sel_o SHALL advance by one, wrapping 3->0.
REQ-027 In fixed mode, sel_o SHALL never change while busy_o=1.
REQ-028 enh_o SHALL be 1 in RUN and HOLD, and 0 in IDLE.
REQ-029 sel_o SHALL be registered and SHALL hold its last value in IDLE.
REQ-030 In RUN or HOLD, stop_i SHALL force the next state to IDLE and clear the dwell counter; a write in that same cycle still occurs per REQ-020.
REQ-031 stop_i SHALL take priority over start_i when both are asserted; start_i while busy_o=1 SHALL be ignored.

Reset
REQ-032 rst_ni=0 SHALL immediately force state IDLE, sel_o=0, enh_o=0, fifo_wr_o=0, busy_o=0, dwell counter 0 and latched configuration 0, including when asserted mid-RUN or mid-HOLD.

Configuration
REQ-033 With macro FGEN_STALL_CNT_EN defined, the block SHALL add output stall_cnt_o (16 bits): a saturating count of HOLD cycles since the last start, cleared on start and on reset.
REQ-034 Without FGEN_STALL_CNT_EN, stall_cnt_o and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-035 Package funct_generator_pkg SHALL hold the FSM state enum, the mode enum (MODE_FIXED, MODE_SWEEP) and the waveform count constant 4.
REQ-036 The block SHALL be a single module with no sub-module.
REQ-037 The top-level SHALL connect sel_o and enh_o to the existing multiplexer sel_i and enh ports.

Verification
REQ-038 Reset mid-RUN: assert rst_ni=0 -> sel_o=0, enh_o=0, fifo_wr_o=0 and busy_o=0 before the next clock edge.
REQ-039 Fixed mode, wave_sel=2, dwell=5, FIFO never full, start -> fifo_wr_o=1 every cycle and sel_o=2 throughout, until stop.
REQ-040 Sweep mode, wave_sel=3, dwell=3, FIFO never full -> sel_o sequence 3,3,3,0,0,0,1,1,1,2,2,2,3.
REQ-041 Sweep mode, dwell=2, fifo_full_i=1 for 4 cycles after the first write -> fifo_wr_o low for those cycles, sel_o unchanged, and 1 more write before advancing; with FGEN_STALL_CNT_EN defined, stall_cnt_o=4.
REQ-042 Sweep mode, dwell=0 -> sel_o advances after every write.
REQ-043 start_i and stop_i asserted together in IDLE -> remains IDLE, busy_o=0; stop_i during HOLD -> IDLE next cycle, enh_o=0.
